serial_tx: RTL and testbench

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_pkg.sv | 16 +
 rtl/bit_timer.sv | 40 ++++
 rtl/serial_tx.sv | 136 +++++++++++++
 tb/tb_serial_tx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared serial-link definitions.
// Holds the frame state encoding and its width so that the transmitter and the
// future receiver decode the same states.
package serial_pkg;

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } serial_state_e;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer.
// Counts clock cycles within one serial bit and pulses bit_end on the last cycle
// of each bit. The count wraps to 0 after CLKS_PER_BIT-1.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   restart  - hold the count at 0 (used while the line is idle)
//   bit_end  - high during the last cycle of the current bit
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign bit_end = (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Asynchronous-serial transmitter.
// Sends one frame per accepted word: start bit (0), DATA_W data bits LSB first,
// optional even-parity bit, stop bit (1). Each bit lasts CLKS_PER_BIT cycles.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset; aborts any frame in progress
//   tx_data  - payload, captured on acceptance
//   tx_valid - payload valid; accepted when tx_ready is high
//   tx_ready - idle and able to accept a frame
//   tx_out   - registered serial line, idle high
//   tx_busy  - frame in progress (inverse of tx_ready)
//   tx_done  - one-cycle pulse in the first idle cycle after a frame
module serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int unsigned IdxW = $clog2(DATA_W);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_W - 1);

  serial_state_e     state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              parity_q, parity_d;
  logic              out_q, out_d;
  logic              done_q, done_d;
  logic              bit_end;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .restart(state_q == StIdle),
    .bit_end(bit_end)
  );

  assign tx_ready = (state_q == StIdle);
  assign tx_busy  = ~tx_ready;
  assign tx_out   = out_q;
  assign tx_done  = done_q;

  // out_d is the line level for the state being entered, so tx_out is a pure flop.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    parity_d = parity_q;
    out_d    = out_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        out_d = 1'b1;
        if (tx_valid) begin
          state_d  = StStart;
          shift_d  = tx_data;
          parity_d = ^tx_data;
          idx_d    = '0;
          out_d    = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          out_d   = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          if (idx_q == IdxLast) begin
            idx_d = '0;
            if (PARITY_EN != 0) begin
              state_d = StParity;
              out_d   = parity_q;
            end else begin
              state_d = StStop;
              out_d   = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
            out_d   = shift_q[1];
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          out_d   = 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
          out_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        out_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      idx_q    <= '0;
      parity_q <= 1'b0;
      out_q    <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      parity_q <= parity_d;
      out_q    <= out_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: three instances (defaults, parity enabled,
// one clock per bit) share clk/rst; sel picks which one is driven and observed.
module tb_serial_tx;

  logic       clk;
  logic       rst;
  logic [7:0] tb_data;
  logic       tb_valid;
  int         sel;

  logic out0, ready0, busy0, done0;
  logic out1, ready1, busy1, done1;
  logic out2, ready2, busy2, done2;
  logic cur_out, cur_ready, cur_busy, cur_done;

  int n_checks;
  int n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_tx dut_def (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tb_data),
    .tx_valid(tb_valid && (sel == 0)),
    .tx_ready(ready0),
    .tx_out  (out0),
    .tx_busy (busy0),
    .tx_done (done0)
  );

  serial_tx #(
    .PARITY_EN(1)
  ) dut_par (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tb_data),
    .tx_valid(tb_valid && (sel == 1)),
    .tx_ready(ready1),
    .tx_out  (out1),
    .tx_busy (busy1),
    .tx_done (done1)
  );

  serial_tx #(
    .CLKS_PER_BIT(1)
  ) dut_fast (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tb_data),
    .tx_valid(tb_valid && (sel == 2)),
    .tx_ready(ready2),
    .tx_out  (out2),
    .tx_busy (busy2),
    .tx_done (done2)
  );

  always_comb begin
    cur_out   = out0;
    cur_ready = ready0;
    cur_busy  = busy0;
    cur_done  = done0;
    if (sel == 1) begin
      cur_out   = out1;
      cur_ready = ready1;
      cur_busy  = busy1;
      cur_done  = done1;
    end else if (sel == 2) begin
      cur_out   = out2;
      cur_ready = ready2;
      cur_busy  = busy2;
      cur_done  = done2;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a word for one accepting edge, then optionally drop valid and
  // swap the data bus to after_data.
  task automatic accept(input logic [7:0] data, input bit hold, input logic [7:0] after_data);
    @(negedge clk);
    tb_data  = data;
    tb_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) tb_valid = 1'b0;
    tb_data = after_data;
  endtask

  // bits[i] is the expected line level for bit slot i (slot 0 = start).
  task automatic check_frame(input string tag, input logic [11:0] bits, input int nbits,
                             input int k, input bit drop_valid);
    int busy_cnt;
    busy_cnt = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < k; c++) begin
        @(negedge clk);
        if (drop_valid) tb_valid = 1'b0;
        check_eq({tag, " line"}, {31'd0, cur_out}, {31'd0, bits[b]});
        check_eq({tag, " ready"}, {31'd0, cur_ready}, 32'd0);
        check_eq({tag, " done"}, {31'd0, cur_done}, 32'd0);
        if (cur_busy) busy_cnt++;
      end
    end
    check_eq({tag, " len"}, busy_cnt, nbits * k);
  endtask

  task automatic check_idle_end(input string tag);
    @(negedge clk);
    check_eq({tag, " end done"}, {31'd0, cur_done}, 32'd1);
    check_eq({tag, " end ready"}, {31'd0, cur_ready}, 32'd1);
    check_eq({tag, " end line"}, {31'd0, cur_out}, 32'd1);
    check_eq({tag, " end busy"}, {31'd0, cur_busy}, 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    @(negedge clk);
    check_eq({tag, " quiet done"}, {31'd0, cur_done}, 32'd0);
    check_eq({tag, " quiet line"}, {31'd0, cur_out}, 32'd1);
    check_eq({tag, " quiet ready"}, {31'd0, cur_ready}, 32'd1);
  endtask

  initial begin
    int done_cnt;
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    tb_valid = 1'b0;
    tb_data  = 8'h00;
    sel      = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state of every instance.
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_eq("rst line", {31'd0, cur_out}, 32'd1);
      check_eq("rst ready", {31'd0, cur_ready}, 32'd1);
      check_eq("rst busy", {31'd0, cur_busy}, 32'd0);
      check_eq("rst done", {31'd0, cur_done}, 32'd0);
    end
    sel = 0;

    // 0xA5, defaults: 40-cycle frame, done on cycle 41.
    accept(8'hA5, 1'b0, 8'hA5);
    check_frame("a5", 12'b00_1_10100101_0, 10, 4, 1'b0);
    check_idle_end("a5");
    check_quiet("a5");

    // Reset wins over a simultaneous valid.
    @(negedge clk);
    rst      = 1'b1;
    tb_valid = 1'b1;
    tb_data  = 8'h12;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    tb_valid = 1'b0;
    @(negedge clk);
    check_eq("rstprio ready", {31'd0, cur_ready}, 32'd1);
    check_eq("rstprio busy", {31'd0, cur_busy}, 32'd0);
    check_eq("rstprio line", {31'd0, cur_out}, 32'd1);

    // Back-to-back with valid held high: one idle-high cycle between frames.
    accept(8'h3C, 1'b1, 8'hC3);
    check_frame("b2b 3c", 12'b00_1_00111100_0, 10, 4, 1'b0);
    check_idle_end("b2b gap");
    check_frame("b2b c3", 12'b00_1_11000011_0, 10, 4, 1'b1);
    check_idle_end("b2b c3");
    check_quiet("b2b");

    // Data bus changes after acceptance are ignored.
    accept(8'h00, 1'b0, 8'hFF);
    check_frame("hold", 12'b00_1_00000000_0, 10, 4, 1'b0);
    check_idle_end("hold");

    // Reset during data bit 3 aborts the frame without a done pulse.
    accept(8'h00, 1'b0, 8'h00);
    repeat (16) @(negedge clk);
    @(negedge clk);
    check_eq("abort bit3 line", {31'd0, cur_out}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("abort line", {31'd0, cur_out}, 32'd1);
    check_eq("abort ready", {31'd0, cur_ready}, 32'd1);
    check_eq("abort busy", {31'd0, cur_busy}, 32'd0);
    check_eq("abort done", {31'd0, cur_done}, 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (cur_done) done_cnt++;
    end
    check_eq("abort no done", done_cnt, 0);
    accept(8'h55, 1'b0, 8'h00);
    check_frame("post 55", 12'b00_1_01010101_0, 10, 4, 1'b0);
    check_idle_end("post 55");

    // Parity instance: 0x07 -> parity 1, 0xA5 -> parity 0, 44-cycle frames.
    @(negedge clk);
    sel = 1;
    accept(8'h07, 1'b0, 8'h00);
    check_frame("par 07", 12'b0_1_1_00000111_0, 11, 4, 1'b0);
    check_idle_end("par 07");
    accept(8'hA5, 1'b0, 8'h00);
    check_frame("par a5", 12'b0_1_0_10100101_0, 11, 4, 1'b0);
    check_idle_end("par a5");

    // One clock per bit: 0x81 -> 10-cycle frame.
    @(negedge clk);
    sel = 2;
    accept(8'h81, 1'b0, 8'h00);
    check_frame("fast 81", 12'b00_1_10000001_0, 10, 1, 1'b0);
    check_idle_end("fast 81");
    check_quiet("fast 81");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
